// File: rtl/stream_write_scheduler.sv
// Stream test write scheduler: captures generator words into a small FIFO and
// drains them to the SDRAM write port as fixed-length bursts at incrementing addresses.
module stream_write_scheduler #(
    parameter int DEPTH       = 8,
    parameter int BURST_LEN   = 4,
    parameter int WORDS_TOTAL = 1024,
    parameter int ADDR_W      = 22
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              gen_en,
    input  logic [31:0]       s32,
    input  logic              n32rdy,
    output logic              wr_req,
    input  logic              wr_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              wr_data_valid,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int WC_W  = $clog2(WORDS_TOTAL) + 1;
    localparam int BC_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_REQ, S_BURST, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
    logic [WC_W-1:0]   captured_q, captured_d, written_q, written_d;
    logic [BC_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              overflow_q, overflow_d;
    logic              gen_en_q, gen_en_d, wr_req_q, wr_req_d;
    logic              valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic              pop, push_try, push, fifo_full;

    logic [31:0] mem [DEPTH];

    assign fifo_full = (fifo_count_q == CNT_W'(DEPTH));
    assign pop       = valid_q;
    assign push_try  = gen_en_q & n32rdy;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push      = push_try & (~fifo_full | pop);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        captured_d   = captured_q;
        written_d    = written_q;
        beat_d       = beat_q;
        addr_d       = addr_q;
        overflow_d   = overflow_q;

        if (push) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            captured_d = captured_q + 1'b1;
        end else if (push_try) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            fifo_count_d = fifo_count_q + 1'b1;
        end else if (pop && !push) begin
            fifo_count_d = fifo_count_q - 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RUN;
                    captured_d   = '0;
                    written_d    = '0;
                    addr_d       = '0;
                    overflow_d   = 1'b0;
                    wr_ptr_d     = '0;
                    rd_ptr_d     = '0;
                    fifo_count_d = '0;
                end
            end
            S_RUN: begin
                if (fifo_count_q >= CNT_W'(BURST_LEN)) begin
                    state_d = S_REQ;
                end else if (written_q == WC_W'(WORDS_TOTAL)) begin
                    state_d = S_DONE;
                end
            end
            S_REQ: begin
                if (wr_ack) begin
                    state_d = S_BURST;
                    beat_d  = '0;
                end
            end
            S_BURST: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == BC_W'(BURST_LEN - 1)) begin
                    addr_d    = addr_q + ADDR_W'(BURST_LEN);
                    written_d = written_q + WC_W'(BURST_LEN);
                    state_d   = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d   = (state_d == S_RUN) || (state_d == S_REQ) || (state_d == S_BURST);
        gen_en_d = busy_d && (captured_d < WC_W'(WORDS_TOTAL));
        wr_req_d = (state_d == S_REQ);
        valid_d  = (state_d == S_BURST);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            captured_q   <= '0;
            written_q    <= '0;
            beat_q       <= '0;
            addr_q       <= '0;
            overflow_q   <= 1'b0;
            gen_en_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            captured_q   <= captured_d;
            written_q    <= written_d;
            beat_q       <= beat_d;
            addr_q       <= addr_d;
            overflow_q   <= overflow_d;
            gen_en_q     <= gen_en_d;
            wr_req_q     <= wr_req_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= s32;
        end
    end

    assign gen_en        = gen_en_q;
    assign wr_req        = wr_req_q;
    assign wr_addr       = addr_q;
    // Gated so the port reads zero outside bursts, including straight after reset.
    assign wr_data       = valid_q ? mem[rd_ptr_q] : 32'h0;
    assign wr_data_valid = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_stream_write_scheduler.sv
// Bench for stream_write_scheduler: cycle-by-cycle reference model with a queue FIFO,
// a table of full runs, and hand-written corner-case sequences.
module tb_stream_write_scheduler;

    localparam int DEPTH  = 8;
    localparam int BL     = 4;
    localparam int TOTAL  = 16;
    localparam int AW     = 22;
    localparam int TOTAL2 = 24;
    localparam int AW2    = 4;
    localparam logic [31:0] GEN_BASE = 32'hfafbfcfd;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0, n32rdy = 1'b0, wr_ack = 1'b0;
    logic [31:0]   s32 = 32'h0;
    logic          gen_en, wr_req, wr_data_valid, busy, done, overflow;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;

    logic           start2 = 1'b0, n32rdy2 = 1'b0, wr_ack2 = 1'b0;
    logic [31:0]    s32_2 = 32'h0;
    logic           gen_en2, wr_req2, wr_data_valid2, busy2, done2, overflow2;
    logic [AW2-1:0] wr_addr2;
    logic [31:0]    wr_data2;

    always #5 clk = ~clk;

    stream_write_scheduler #(.DEPTH(DEPTH), .BURST_LEN(BL), .WORDS_TOTAL(TOTAL), .ADDR_W(AW)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .gen_en(gen_en), .s32(s32), .n32rdy(n32rdy),
        .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_data_valid(wr_data_valid), .busy(busy), .done(done), .overflow(overflow));

    stream_write_scheduler #(.DEPTH(DEPTH), .BURST_LEN(BL), .WORDS_TOTAL(TOTAL2), .ADDR_W(AW2)) dut2 (
        .clk(clk), .n_rst(n_rst), .start(start2), .gen_en(gen_en2), .s32(s32_2), .n32rdy(n32rdy2),
        .wr_req(wr_req2), .wr_ack(wr_ack2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .wr_data_valid(wr_data_valid2), .busy(busy2), .done(done2), .overflow(overflow2));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 run, 2 request, 3 burst, 4 done.
    int            m_phase, m_captured, m_written, m_bcount;
    logic [AW-1:0] m_addr;
    bit            m_ovf;
    logic [31:0]   mq[$];

    task automatic model_reset();
        m_phase = 0; m_captured = 0; m_written = 0; m_bcount = 0;
        m_addr = '0; m_ovf = 0; mq.delete();
    endtask

    task automatic model_step();
        int size0;
        bit pop, push_try, m_gen;
        logic [31:0] head;
        if (!n_rst) begin
            model_reset();
            return;
        end
        m_gen    = (m_phase >= 1 && m_phase <= 3) && (m_captured < TOTAL);
        pop      = (m_phase == 3);
        size0    = mq.size();
        push_try = m_gen && n32rdy;
        if (pop && size0 > 0) begin
            head = mq.pop_front();
        end
        if (push_try) begin
            if (size0 < DEPTH || pop) begin
                mq.push_back(s32);
                m_captured++;
            end else begin
                m_ovf = 1;
            end
        end
        case (m_phase)
            0, 4: if (start) begin
                m_phase = 1; m_captured = 0; m_written = 0; m_addr = '0; m_ovf = 0; mq.delete();
            end
            1: if (size0 >= BL) m_phase = 2; else if (m_written == TOTAL) m_phase = 4;
            2: if (wr_ack) begin m_phase = 3; m_bcount = 0; end
            3: begin
                m_bcount++;
                if (m_bcount == BL) begin
                    m_addr = m_addr + AW'(BL);
                    m_written += BL;
                    m_phase = 1;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare();
        bit mb;
        logic [5:0]  exp_flags;
        logic [31:0] exp_data;
        mb        = (m_phase >= 1 && m_phase <= 3);
        exp_flags = {mb && (m_captured < TOTAL), m_phase == 2, m_phase == 3, mb, m_phase == 4, m_ovf};
        exp_data  = (m_phase == 3 && mq.size() > 0) ? mq[0] : 32'h0;
        check("flags{gen_en,wr_req,valid,busy,done,ovf}",
              {gen_en, wr_req, wr_data_valid, busy, done, overflow}, exp_flags);
        check("wr_addr", wr_addr, m_addr);
        check("wr_data", wr_data, exp_data);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    // Stimulus state
    logic [31:0] gen_word;
    logic [31:0] data_log[$];
    logic [AW-1:0] addr_log[$];
    int  first_ack, ack_dly, req_cnt, nreq, gen_limit;
    bit  ack_hold, force_ack, force_start, force_rdy;

    task automatic drive();
        bit r;
        int dly;
        if (wr_data_valid) data_log.push_back(wr_data);
        r = 0;
        if (force_rdy) r = 1;
        else if (gen_en && !n32rdy && $urandom_range(0, 1) == 1 &&
                 (gen_limit == 0 || mq.size() < gen_limit)) r = 1;
        n32rdy = r;
        s32 = gen_word;
        if (r) gen_word = gen_word + 1;
        dly = (nreq == 0) ? first_ack : ack_dly;
        if (wr_req) req_cnt++; else req_cnt = 0;
        wr_ack = force_ack || (!ack_hold && wr_req && req_cnt >= dly);
        if (wr_req && wr_ack) begin
            addr_log.push_back(wr_addr);
            $display("burst %0d granted at addr=%0h", nreq, wr_addr);
            nreq++;
        end
        start = force_start;
    endtask

    task automatic begin_run();
        data_log.delete(); addr_log.delete();
        nreq = 0; req_cnt = 0; gen_word = GEN_BASE;
        force_start = 1;
        drive();
        tick();
        force_start = 0;
    endtask

    task automatic run_to_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            drive();
            tick();
            n++;
        end
        check("run_reached_done", done, 1'b1);
    endtask

    task automatic check_run(input bit exp_ovf, input bit contig);
        logic [31:0] expw;
        check("burst_count", addr_log.size(), TOTAL / BL);
        for (int i = 0; i < addr_log.size(); i++) check("burst_addr", addr_log[i], i * BL);
        check("word_count", data_log.size(), TOTAL);
        for (int i = 0; i < data_log.size(); i++) begin
            expw = GEN_BASE + i;
            if (contig || i < DEPTH) check("wr_data_seq", data_log[i], expw);
            else check("wr_data_ascending", data_log[i] > data_log[i-1], 1'b1);
        end
        check("end_overflow", overflow, exp_ovf);
        check("end_done", done, 1'b1);
        check("end_gen_en", gen_en, 1'b0);
        check("end_busy", busy, 1'b0);
        $display("run complete: %0d bursts, %0d words, overflow=%0b", addr_log.size(), data_log.size(), overflow);
    endtask

    typedef struct {
        int first_ack;
        int ack;
        bit exp_ovf;
        bit contig;
    } run_t;

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        run_t runs[2];
        int n;
        logic [AW2-1:0] a2_log[$];
        logic [31:0]    d2_log[$];
        logic [31:0]    w2, expw;
        int             cnt2;
        int             exp_a2[6];

        runs[0] = '{first_ack: 2,   ack: 2, exp_ovf: 1'b0, contig: 1'b1};
        runs[1] = '{first_ack: 200, ack: 2, exp_ovf: 1'b1, contig: 1'b0};
        exp_a2  = '{0, 4, 8, 12, 0, 4};

        model_reset();
        gen_word = GEN_BASE; first_ack = 2; ack_dly = 2; req_cnt = 0; nreq = 0; gen_limit = 0;
        ack_hold = 0; force_ack = 0; force_start = 0; force_rdy = 0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {gen_en, wr_req, wr_data_valid, busy, done, overflow, wr_addr, wr_data}, 64'h0);
        check("reset_outputs_dut2", {gen_en2, wr_req2, wr_data_valid2, busy2, done2, overflow2, wr_addr2, wr_data2}, 64'h0);
        n_rst = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 2; r++) begin
            first_ack = runs[r].first_ack;
            ack_dly   = runs[r].ack;
            begin_run();
            run_to_done(3000);
            check_run(runs[r].exp_ovf, runs[r].contig);
        end

        // Push arriving on the first pop of a burst while the FIFO is full.
        first_ack = 2; ack_hold = 1; gen_limit = DEPTH;
        begin_run();
        n = 0;
        while ((mq.size() < DEPTH || !wr_req) && n < 300) begin drive(); tick(); n++; end
        check("fifo_fill_timeout", n < 300, 1'b1);
        force_ack = 1; drive(); tick(); force_ack = 0;
        check("burst_after_ack", wr_data_valid, 1'b1);
        force_rdy = 1; drive(); tick(); force_rdy = 0;
        check("ovf_push_on_full_pop", overflow, 1'b0);
        ack_hold = 0; gen_limit = 0;
        run_to_done(3000);
        check_run(1'b0, 1'b1);

        // Reset in the middle of the second burst, then a fresh run.
        begin_run();
        n = 0;
        while (!(addr_log.size() == 2 && wr_data_valid) && n < 1000) begin drive(); tick(); n++; end
        check("second_burst_timeout", n < 1000, 1'b1);
        n_rst = 1'b0; n32rdy = 1'b0; wr_ack = 1'b0; start = 1'b0;
        tick();
        check("reset_midrun_outputs", {gen_en, wr_req, wr_data_valid, busy, done, overflow, wr_addr, wr_data}, 64'h0);
        tick();
        n_rst = 1'b1;
        tick();
        begin_run();
        run_to_done(3000);
        check_run(1'b0, 1'b1);

        // Start pulses while busy and wr_ack pulses while in RUN must be ignored.
        begin_run();
        n = 0;
        while (!done && n < 3000) begin
            force_ack   = (m_phase == 1);
            force_start = (m_phase >= 1 && m_phase <= 3) && ($urandom_range(0, 2) == 0);
            drive();
            tick();
            n++;
        end
        force_ack = 0; force_start = 0;
        check("run_reached_done", done, 1'b1);
        check_run(1'b0, 1'b1);

        // Narrow address run: wr_addr wraps modulo 16.
        w2 = GEN_BASE; cnt2 = 0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 3000) begin
            if (wr_data_valid2) d2_log.push_back(wr_data2);
            n32rdy2 = gen_en2 && !n32rdy2 && ($urandom_range(0, 1) == 1);
            s32_2 = w2;
            if (n32rdy2) w2 = w2 + 1;
            if (wr_req2) cnt2++; else cnt2 = 0;
            wr_ack2 = wr_req2 && cnt2 >= 2;
            if (wr_req2 && wr_ack2) begin
                a2_log.push_back(wr_addr2);
                $display("dut2 burst granted at addr=%0h", wr_addr2);
            end
            @(negedge clk);
            n++;
        end
        n32rdy2 = 1'b0; wr_ack2 = 1'b0;
        check("dut2_done", done2, 1'b1);
        check("dut2_burst_count", a2_log.size(), 6);
        for (int i = 0; i < a2_log.size() && i < 6; i++) check("dut2_burst_addr", a2_log[i], exp_a2[i]);
        check("dut2_word_count", d2_log.size(), TOTAL2);
        for (int i = 0; i < d2_log.size(); i++) begin
            expw = GEN_BASE + i;
            check("dut2_wr_data_seq", d2_log[i], expw);
        end
        check("dut2_overflow", overflow2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
